// File: rtl/kmeans_pkg.sv
// Shared definitions for the K-means seeding front end.
// Contents:
//   IDX_W_DEF, NUM_POINTS_DEF : default index width / point count
//   K_MAX                     : largest supported centroid count
//   seed_state_e              : centroid_seed_select state encoding
//   slot_width()              : width of a centroid slot number (min 1)
package kmeans_pkg;

  localparam int unsigned IDX_W_DEF      = 13;
  localparam int unsigned NUM_POINTS_DEF = 5000;
  localparam int unsigned K_MAX          = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } seed_state_e;

  // Slot numbers need at least one bit even when K == 1.
  function automatic int unsigned slot_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/seed_dup_check.sv
// Combinational duplicate detector for the seed table.
// Ports:
//   cand     : candidate index
//   seed_tbl : K-entry table of accepted indices
//   count    : number of valid entries (entries 0..count-1 are compared)
//   hit_c    : candidate equals a valid table entry
module seed_dup_check
  import kmeans_pkg::*;
#(
  parameter int unsigned K     = 4,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = $clog2(K + 1)
) (
  input  logic [IDX_W-1:0]        cand,
  input  logic [K-1:0][IDX_W-1:0] seed_tbl,
  input  logic [CNT_W-1:0]        count,
  output logic                    hit_c
);

  // K-way compare, masked so stale entries from earlier rounds never match.
  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < K; i++) begin
      if ((CNT_W'(i) < count) && (seed_tbl[i] == cand)) begin
        hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/centroid_seed_select.sv
// Picks K distinct in-range point indices from the Random_2 stream and
// streams them to the centroid-load stage.
// Optional build macro: SEED_TIMEOUT_EN (forced fallback seed after
// MAX_TRIES consecutive rejects; without it fallback is tied 0).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : one-cycle round request (honoured only when idle)
//   rnd             : Random_2 count, sampled every COLLECT cycle
//   busy            : round in progress
//   idx_valid/ready : seed handshake
//   idx_out         : seed point index
//   idx_slot        : centroid slot for idx_out
//   done            : one-cycle pulse after the last seed is taken
//   fallback        : sticky per round, a seed was forced
module centroid_seed_select
  import kmeans_pkg::*;
#(
  parameter int unsigned K          = 4,
  parameter int unsigned IDX_W      = IDX_W_DEF,
  parameter int unsigned NUM_POINTS = NUM_POINTS_DEF,
  parameter int unsigned MAX_TRIES  = 64,
  localparam int unsigned SLOT_W    = slot_width(K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  rnd,
  output logic              busy,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDX_W-1:0]  idx_out,
  output logic [SLOT_W-1:0] idx_slot,
  output logic              done,
  output logic              fallback
);

  localparam int unsigned CNT_W = $clog2(K + 1);

  // A misconfigured instance refuses to start rather than emit bad seeds.
  localparam bit PARAMS_OK = (K >= 1) && (K <= K_MAX) && (NUM_POINTS >= K) &&
                             (64'(NUM_POINTS) <= (64'(1) << IDX_W)) &&
                             (MAX_TRIES >= 1);

  seed_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [K-1:0][IDX_W-1:0] tbl_q, tbl_d;
  logic                    busy_q, busy_d;
  logic                    idx_valid_q, idx_valid_d;
  logic [IDX_W-1:0]        idx_out_q, idx_out_d;
  logic [SLOT_W-1:0]       idx_slot_q, idx_slot_d;
  logic                    done_q, done_d;

  logic [IDX_W-1:0]        cand_c;
  logic                    in_range_c;
  logic                    hit_c;
  logic                    accept_c;

`ifdef SEED_TIMEOUT_EN
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  logic [TRY_W-1:0] rej_q, rej_d;
  logic [IDX_W-1:0] probe_q, probe_d;
  logic             fallback_q, fallback_d;
  logic             forcing_c;

  // Once the reject budget is spent, the probe replaces rnd as candidate
  // and walks upward from 0 past table hits until a free index is found.
  assign forcing_c = (rej_q == TRY_W'(MAX_TRIES));
  assign cand_c    = forcing_c ? probe_q : rnd;
  assign fallback  = fallback_q;
`else
  assign cand_c    = rnd;
  assign fallback  = 1'b0;
`endif

  assign in_range_c = ({1'b0, cand_c} < (IDX_W + 1)'(NUM_POINTS));
  assign accept_c   = in_range_c & ~hit_c;

  // Single comparator serves both the random candidate and the probe.
  seed_dup_check #(
    .K     (K),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_dup_check (
    .cand     (cand_c),
    .seed_tbl (tbl_q),
    .count    (cnt_q),
    .hit_c    (hit_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tbl_d       = tbl_q;
    busy_d      = busy_q;
    idx_valid_d = idx_valid_q;
    idx_out_d   = idx_out_q;
    idx_slot_d  = idx_slot_q;
    done_d      = 1'b0;
`ifdef SEED_TIMEOUT_EN
    rej_d       = rej_q;
    probe_d     = probe_q;
    fallback_d  = fallback_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start && PARAMS_OK) begin
          state_d = ST_COLLECT;
          busy_d  = 1'b1;
          cnt_d   = '0;
`ifdef SEED_TIMEOUT_EN
          rej_d      = '0;
          probe_d    = '0;
          fallback_d = 1'b0;
`endif
        end
      end

      ST_COLLECT: begin
        if (accept_c) begin
          for (int unsigned i = 0; i < K; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              tbl_d[i] = cand_c;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(K - 1)) begin
            // tbl_d already holds this cycle's write, which matters for K == 1.
            state_d     = ST_EMIT;
            idx_valid_d = 1'b1;
            idx_slot_d  = '0;
            idx_out_d   = tbl_d[0];
          end
        end
`ifdef SEED_TIMEOUT_EN
        if (accept_c) begin
          rej_d   = '0;
          probe_d = '0;
          if (forcing_c) begin
            fallback_d = 1'b1;
          end
        end else if (forcing_c) begin
          probe_d = probe_q + IDX_W'(1);
        end else begin
          rej_d = rej_q + TRY_W'(1);
        end
`endif
      end

      ST_EMIT: begin
        if (idx_ready) begin
          if (idx_slot_q == SLOT_W'(K - 1)) begin
            state_d     = ST_DONE;
            idx_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_slot_d = idx_slot_q + SLOT_W'(1);
            idx_out_d  = tbl_q[idx_slot_d];
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any round in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tbl_q       <= '0;
      busy_q      <= 1'b0;
      idx_valid_q <= 1'b0;
      idx_out_q   <= '0;
      idx_slot_q  <= '0;
      done_q      <= 1'b0;
`ifdef SEED_TIMEOUT_EN
      rej_q       <= '0;
      probe_q     <= '0;
      fallback_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tbl_q       <= tbl_d;
      busy_q      <= busy_d;
      idx_valid_q <= idx_valid_d;
      idx_out_q   <= idx_out_d;
      idx_slot_q  <= idx_slot_d;
      done_q      <= done_d;
`ifdef SEED_TIMEOUT_EN
      rej_q       <= rej_d;
      probe_q     <= probe_d;
      fallback_q  <= fallback_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign idx_valid = idx_valid_q;
  assign idx_out   = idx_out_q;
  assign idx_slot  = idx_slot_q;
  assign done      = done_q;

endmodule

// File: tb/tb_centroid_seed_select.sv
// Self-checking bench for centroid_seed_select (default parameters).
// A round-level model (phase + queue of accepted seeds) predicts every
// output each cycle; directed rounds pin the model with literal seed lists.
module tb_centroid_seed_select;

  localparam int K          = 4;
  localparam int IDX_W      = 13;
  localparam int NUM_POINTS = 5000;
  localparam int SLOT_W     = 2;
`ifdef SEED_TIMEOUT_EN
  localparam int MAX_TRIES  = 64;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [IDX_W-1:0]  rnd = '0;
  logic              idx_ready = 1'b0;
  logic              busy;
  logic              idx_valid;
  logic [IDX_W-1:0]  idx_out;
  logic [SLOT_W-1:0] idx_slot;
  logic              done;
  logic              fallback;

  centroid_seed_select dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rnd       (rnd),
    .busy      (busy),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx_out   (idx_out),
    .idx_slot  (idx_slot),
    .done      (done),
    .fallback  (fallback)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_COLLECT, P_EMIT, P_DONE} ph_e;
  ph_e ph = P_IDLE;
  int  m_seeds[$];
  int  m_emit = 0;
  bit  m_fb = 1'b0;
`ifdef SEED_TIMEOUT_EN
  int  rejs = 0;
  int  probe = 0;
`endif

  function automatic bit in_set(input int v);
    foreach (m_seeds[i]) if (m_seeds[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    ph = P_IDLE;
    m_seeds.delete();
    m_emit = 0;
    m_fb = 1'b0;
`ifdef SEED_TIMEOUT_EN
    rejs = 0;
    probe = 0;
`endif
  endtask

  task automatic model_step(input bit s_start, input int s_rnd, input bit s_ready);
    int c;
    bit acc;
    case (ph)
      P_IDLE: if (s_start) begin
        model_reset();
        ph = P_COLLECT;
      end
      P_COLLECT: begin
        c = s_rnd;
`ifdef SEED_TIMEOUT_EN
        if (rejs == MAX_TRIES) c = probe;
`endif
        acc = (c < NUM_POINTS) && !in_set(c);
`ifdef SEED_TIMEOUT_EN
        if (rejs == MAX_TRIES) begin
          if (acc) begin m_fb = 1'b1; rejs = 0; probe = 0; end
          else probe++;
        end else if (acc) rejs = 0;
        else rejs++;
`endif
        if (acc) begin
          m_seeds.push_back(c);
          if (m_seeds.size() == K) begin
            ph = P_EMIT;
            m_emit = 0;
          end
        end
      end
      P_EMIT: if (s_ready) begin
        m_emit++;
        if (m_emit == K) ph = P_DONE;
      end
      default: ph = P_IDLE;
    endcase
  endtask

  // ---------------- observation / compare process ----------------
  int               cyc = 0;
  int               done_cnt = 0;
  int               coll_cyc = 0;
  int               got_val[$];
  int               got_slot[$];
  int               hs_cyc[$];
  bit               p_valid = 1'b0;
  logic [IDX_W-1:0] p_out = '0;
  logic [SLOT_W-1:0] p_slot = '0;

  initial begin : cmp
    bit s_start, s_ready, s_rst;
    int s_rnd;
    forever begin
      @(posedge clk);
      s_start = start;
      s_ready = idx_ready;
      s_rst   = rst;
      s_rnd   = int'(rnd);
      cyc++;
      if (s_rst && p_valid && s_ready) begin
        got_val.push_back(int'(p_out));
        got_slot.push_back(int'(p_slot));
        hs_cyc.push_back(cyc);
      end
      if (!s_rst) model_reset();
      else model_step(s_start, s_rnd, s_ready);
      #1;
      p_valid = idx_valid;
      p_out   = idx_out;
      p_slot  = idx_slot;
      if (rst) begin
        if (done) done_cnt++;
        if (busy && !idx_valid) coll_cyc++;
        check("busy", busy, (ph == P_COLLECT || ph == P_EMIT));
        check("idx_valid", idx_valid, (ph == P_EMIT));
        check("done", done, (ph == P_DONE));
        check("fallback", fallback, m_fb);
        if (ph == P_EMIT) begin
          check("idx_out", idx_out, m_seeds[m_emit]);
          check("idx_slot", idx_slot, m_emit);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    got_val.delete();
    got_slot.delete();
    hs_cyc.delete();
    coll_cyc = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int v[8], input int n);
    for (int i = 0; i < n; i++) begin
      rnd = IDX_W'(v[i]);
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, seen, 1);
  endtask

  task automatic check_seeds(input string name, input int e[4]);
    check({name, "_count"}, got_val.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_val.size()) begin
        check({name, "_seed"}, got_val[i], e[i]);
        check({name, "_slot"}, got_slot[i], i);
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin : stim
    int d0;
    int r;

    // Reset and idle
    repeat (10) @(negedge clk);
    check("reset_outputs", {busy, idx_valid, idx_out, idx_slot, done, fallback}, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_no_start", {busy, idx_valid}, 0);

    // Clean round
    idx_ready = 1'b1;
    clear_log();
    d0 = done_cnt;
    do_start();
    feed('{10, 20, 30, 40, 0, 0, 0, 0}, 4);
    wait_done("clean", 40);
    check("clean_done_busy", busy, 0);
    check_seeds("clean", '{10, 20, 30, 40});
    if (hs_cyc.size() == 4) check("clean_consecutive", hs_cyc[3] - hs_cyc[0], 3);
    else check("clean_hs_count", hs_cyc.size(), 4);
    check("clean_collect_cycles", coll_cyc, 4);
    repeat (3) @(negedge clk);
    check("clean_one_done", done_cnt - d0, 1);
`ifndef SEED_TIMEOUT_EN
    check("fallback_tied", fallback, 0);
`endif

    // Rejection of duplicates and out-of-range values
    clear_log();
    do_start();
    feed('{10, 10, 6000, 8191, 20, 10, 30, 40}, 8);
    wait_done("reject", 40);
    check_seeds("reject", '{10, 20, 30, 40});
    check("reject_collect_cycles", coll_cyc, 8);

    // Back-pressure
    idx_ready = 1'b0;
    clear_log();
    do_start();
    feed('{10, 20, 30, 40, 0, 0, 0, 0}, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", idx_valid, 1);
      check("bp_out", idx_out, 10);
      check("bp_slot", idx_slot, 0);
      @(negedge clk);
    end
    idx_ready = 1'b1; @(negedge clk);
    idx_ready = 1'b0; @(negedge clk);
    idx_ready = 1'b1; @(negedge clk);
    idx_ready = 1'b1;
    wait_done("bp", 40);
    check_seeds("bp", '{10, 20, 30, 40});

    // Reset in the middle of a round
    clear_log();
    d0 = done_cnt;
    do_start();
    feed('{5, 6, 0, 0, 0, 0, 0, 0}, 2);
    rst = 1'b0;
    #1;
    check("midrst_outputs", {busy, idx_valid, idx_out, idx_slot, done, fallback}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);
    clear_log();
    do_start();
    feed('{1, 2, 3, 4, 0, 0, 0, 0}, 4);
    wait_done("midrst", 40);
    check_seeds("midrst", '{1, 2, 3, 4});

`ifdef SEED_TIMEOUT_EN
    // Stuck generator forces fallback seeds
    clear_log();
    do_start();
    rnd = IDX_W'(7);
    wait_done("stuck", 400);
    check("stuck_fallback", fallback, 1);
    check_seeds("stuck", '{7, 0, 1, 2});
`endif

    // Randomized traffic
    d0 = done_cnt;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      idx_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 6) rnd = IDX_W'($urandom_range(0, 11));
      else if (r < 8) rnd = IDX_W'($urandom_range(4990, 5010));
      else rnd = IDX_W'($urandom_range(0, 8191));
    end
    @(negedge clk);
    start = 1'b0;
    idx_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rnd = IDX_W'($urandom_range(0, 4999));
      @(negedge clk);
      if (!busy && !idx_valid) break;
    end
    check("rand_drained", {busy, idx_valid}, 0);
    check("rand_rounds_completed", (done_cnt - d0) > 10, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/centroid_seed_select.md
Name: centroid_seed_select

Overview:
- Consumes the free-running 13-bit pseudo-random count from the Random_2 generator.
- Selects K distinct, in-range point indices to seed the initial K-means centroids.
- Streams the chosen indices to the centroid-load stage over a valid/ready handshake.
- Sits directly downstream of Random_2 and upstream of the point-memory fetch and centroid register file.

Parameters:
- K, 4, number of centroids to seed (1..8).
- IDX_W, 13, index width; matches the Random_2 output width.
- NUM_POINTS, 5000, valid indices are 0..NUM_POINTS-1 (must be ≤ 2^IDX_W).
- MAX_TRIES, 64, consecutive-reject limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; all state clears while rst=0.
- start  in  1  single-cycle request to begin a selection round.
- rnd  in  IDX_W  random count from Random_2; sampled every cycle in COLLECT.
- busy  out  1  high from the accepted start until done.
- idx_valid  out  1  idx_out/idx_slot hold a seed.
- idx_ready  in  1  downstream accepts the seed.
- idx_out  out  IDX_W  selected point index.
- idx_slot  out  $clog2(K) (min 1)  centroid slot number 0..K-1.
- done  out  1  one-cycle pulse after the last seed is accepted.
- fallback  out  1  sticky per round; set if any seed was forced (optional feature only, else tied 0).

Behaviour:
- Reset values: all outputs 0, state IDLE, accepted count 0, seed table cleared.
- States: IDLE, COLLECT, EMIT, DONE.
- IDLE:
  - start=1 → COLLECT next cycle; busy=1 from that cycle.
  - start in any other state is ignored.
- COLLECT, each cycle, candidate c = rnd:
  - Reject if c ≥ NUM_POINTS.
  - Reject if c equals any of the n already-accepted entries (table entries are compared only if slot < n).
  - Otherwise store table[n]=c and n=n+1.
  - Maximum accept rate is 1 per cycle.
  - When n reaches K on an accept, go to EMIT next cycle. Minimum COLLECT duration is K cycles.
- EMIT:
  - Presents table[s] with idx_slot=s and idx_valid=1, starting at s=0.
  - idx_out and idx_slot must stay stable while idx_valid=1 and idx_ready=0.
  - On a handshake (idx_valid & idx_ready): s=s+1.
  - On the handshake at s=K-1: idx_valid drops the next cycle and the state goes to DONE.
  - Back-to-back handshakes are supported: one seed per cycle when idx_ready is held high.
- DONE:
  - done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
  - fallback holds its value until the next accepted start clears it.
- Rejected samples have no side effects; no counter changes without the optional feature.
- Reset asserted mid-round: immediate abort, table discarded, no done pulse. After release, a new start is required.
- K=1: duplicate check is vacuous; the first in-range sample is accepted.

Optional Feature:
- Macro: SEED_TIMEOUT_EN.
- Defined:
  - A reject counter, width $clog2(MAX_TRIES+1), counts consecutive rejects in COLLECT and clears on each accept.
  - When it reaches MAX_TRIES, the next cycle forces an accept of the fallback index F instead of rnd.
  - F is the lowest value in 0..NUM_POINTS-1 not present in the table, found by incrementing a probe from 0 while skipping table hits. The probe is at most K steps and takes 1 cycle per step.
  - fallback is set to 1.
  - Guarantees round completion even with a stuck generator.
- Undefined: no counter and no probe logic. COLLECT may run indefinitely if rnd never yields new in-range values. fallback is tied 0.

Decomposition:
- Package kmeans_pkg:
  - IDX_W and NUM_POINTS defaults.
  - K_MAX=8.
  - State enum encoding for IDLE/COLLECT/EMIT/DONE.
  - Slot-width helper constant.
- Sub-module seed_dup_check:
  - Combinational K-way equality compare of a candidate against the table, masked by the valid-entry count.
  - Returns hit.
  - Reused by the fallback probe.

Test Plan:
- Reset and idle: hold rst=0 for 10 cycles → all outputs 0. Release with no start → busy stays 0 and idx_valid never rises.
- Clean round, K=4: drive rnd=10,20,30,40 on consecutive COLLECT cycles, idx_ready=1 → seeds (0,10)(1,20)(2,30)(3,40) on 4 consecutive cycles, then done=1 for one cycle and busy=0.
- Rejection: rnd sequence 10,10,6000,8191,20,10,30,40 → accepted set 10,20,30,40 in that slot order. Duplicates and values ≥5000 are dropped, and COLLECT lasts 8 cycles.
- Back-pressure: idx_ready=0 for 5 cycles with slot 0 valid → idx_out=10 and idx_slot=0 stable throughout. Release ready, toggle ready 1,0,1,1 → each seed is delivered exactly once and in order.
- Reset mid-round: assert rst=0 after 2 accepts → outputs clear immediately and no done. A new start with rnd=1,2,3,4 yields exactly those seeds.
- With SEED_TIMEOUT_EN, MAX_TRIES=64: rnd stuck at 7 → slot 0=7. After 64 rejects, slot 1=0 is forced, then slot 2=1 and slot 3=2; fallback=1 and done pulses.
